// File: rtl/hamming_dec.sv
// Hamming(21,16) single-error-correcting decoder with a valid/ready handshake
// and saturating counters for corrected and uncorrectable words.
module hamming_dec #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [20:0]      iData,
  input  logic             iValid,
  output logic             oReady,
  output logic [15:0]      oData,
  output logic             oValid,
  input  logic             iReady,
  output logic [4:0]       oSyndrome,
  output logic             oErr,
  output logic             oUncorr,
  output logic [CNT_W-1:0] oCorrCnt,
  output logic [CNT_W-1:0] oUncCnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             r_state;
  logic [20:0]        r_code;
  logic               r_ready;
  logic               r_valid;
  logic [15:0]        r_data;
  logic [4:0]         r_syn;
  logic               r_err;
  logic               r_unc;
  logic [CNT_W-1:0]   r_corr_cnt;
  logic [CNT_W-1:0]   r_unc_cnt;

  logic [4:0]         w_syn;
  logic [20:0]        w_flip;
  logic [15:0]        w_data;
  logic               w_err;
  logic               w_unc;

  // XOR of the 1-based positions of every set bit in the codeword.
  function automatic logic [4:0] calc_syndrome(input logic [20:0] c);
    logic [4:0] s;
    s = 5'd0;
    for (int p = 1; p <= 21; p++) begin
      if (c[p-1]) s = s ^ p[4:0];
    end
    return s;
  endfunction

  // Payload d0..d15 occupies every non-power-of-two position, ascending.
  function automatic logic [15:0] extract(input logic [20:0] c);
    return {c[20:16], c[14:8], c[6:4], c[2]};
  endfunction

  // Syndrome classification and single-bit correction of the captured word.
  always_comb begin
    w_syn  = calc_syndrome(r_code);
    w_flip = 21'd0;
    w_err  = 1'b0;
    w_unc  = 1'b0;
    if (w_syn == 5'd0) begin
      w_flip = 21'd0;
    end else if (w_syn <= 5'd21) begin
      w_flip = 21'd1 << (w_syn - 5'd1);
      w_err  = 1'b1;
    end else begin
      w_unc  = 1'b1;
    end
    w_data = extract(r_code ^ w_flip);
  end

  // Handshake FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_code     <= 21'd0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_data     <= 16'd0;
      r_syn      <= 5'd0;
      r_err      <= 1'b0;
      r_unc      <= 1'b0;
      r_corr_cnt <= {CNT_W{1'b0}};
      r_unc_cnt  <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (iValid) begin
            r_code  <= iData;
            r_ready <= 1'b0;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_data  <= w_data;
          r_syn   <= w_syn;
          r_err   <= w_err;
          r_unc   <= w_unc;
          r_valid <= 1'b1;
          if (w_err && (r_corr_cnt != {CNT_W{1'b1}}))
            r_corr_cnt <= r_corr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (w_unc && (r_unc_cnt != {CNT_W{1'b1}}))
            r_unc_cnt <= r_unc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          r_state <= HOLD;
        end
        HOLD: begin
          if (iReady) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign oReady    = r_ready;
  assign oValid    = r_valid;
  assign oData     = r_data;
  assign oSyndrome = r_syn;
  assign oErr      = r_err;
  assign oUncorr   = r_unc;
  assign oCorrCnt  = r_corr_cnt;
  assign oUncCnt   = r_unc_cnt;

endmodule

// File: tb/tb_hamming_dec.sv
// Directed bench for hamming_dec: a 16-bit-counter instance and a 2-bit-counter
// instance share the same stimulus so saturation is observed alongside decoding.
module tb_hamming_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [20:0] iData = 21'd0;
  logic        iValid = 1'b0;
  logic        iReady = 1'b0;

  logic        a_oReady, a_oValid, a_oErr, a_oUncorr;
  logic [15:0] a_oData;
  logic [4:0]  a_oSyndrome;
  logic [15:0] a_oCorrCnt, a_oUncCnt;

  logic        b_oReady, b_oValid, b_oErr, b_oUncorr;
  logic [15:0] b_oData;
  logic [4:0]  b_oSyndrome;
  logic [1:0]  b_oCorrCnt, b_oUncCnt;

  int checks   = 0;
  int failures = 0;
  int exp_corr = 0;
  int exp_unc  = 0;

  hamming_dec #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(a_oReady),
    .oData(a_oData), .oValid(a_oValid), .iReady(iReady), .oSyndrome(a_oSyndrome),
    .oErr(a_oErr), .oUncorr(a_oUncorr), .oCorrCnt(a_oCorrCnt), .oUncCnt(a_oUncCnt)
  );

  hamming_dec #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(b_oReady),
    .oData(b_oData), .oValid(b_oValid), .iReady(iReady), .oSyndrome(b_oSyndrome),
    .oErr(b_oErr), .oUncorr(b_oUncorr), .oCorrCnt(b_oCorrCnt), .oUncCnt(b_oUncCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_corrA"}, 32'(a_oCorrCnt), 32'(exp_corr));
    check({tag, "_uncA"},  32'(a_oUncCnt),  32'(exp_unc));
    check({tag, "_corrB"}, 32'(b_oCorrCnt), 32'((exp_corr > 3) ? 3 : exp_corr));
    check({tag, "_uncB"},  32'(b_oUncCnt),  32'((exp_unc > 3) ? 3 : exp_unc));
  endtask

  // Accept a word, verify the 2-edge latency and the presented result; leaves DUTs in HOLD.
  task automatic send(input string tag, input logic [20:0] code, input logic [15:0] e_data,
                      input logic [4:0] e_syn, input logic e_err, input logic e_unc);
    iData  = code;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    check({tag, "_dec_valid"}, 32'(a_oValid), 32'd0);
    check({tag, "_dec_ready"}, 32'(a_oReady), 32'd0);
    tick();
    if (e_err) exp_corr++;
    if (e_unc) exp_unc++;
    check({tag, "_valid"},  32'(a_oValid),    32'd1);
    check({tag, "_ready"},  32'(a_oReady),    32'd0);
    check({tag, "_data"},   32'(a_oData),     32'(e_data));
    check({tag, "_syn"},    32'(a_oSyndrome), 32'(e_syn));
    check({tag, "_err"},    32'(a_oErr),      32'(e_err));
    check({tag, "_unc"},    32'(a_oUncorr),   32'(e_unc));
    check({tag, "_dataB"},  32'(b_oData),     32'(e_data));
    check_counts(tag);
  endtask

  task automatic release_word(input string tag, input logic [4:0] e_syn);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check({tag, "_rel_valid"}, 32'(a_oValid),    32'd0);
    check({tag, "_rel_ready"}, 32'(a_oReady),    32'd1);
    check({tag, "_rel_syn"},   32'(a_oSyndrome), 32'(e_syn));
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 32'(a_oReady),    32'd1);
    check("rst_valid", 32'(a_oValid),    32'd0);
    check("rst_data",  32'(a_oData),     32'd0);
    check("rst_syn",   32'(a_oSyndrome), 32'd0);
    check("rst_flags", {30'd0, a_oErr, a_oUncorr}, 32'd0);
    check_counts("rst");

    // iReady outside HOLD must be ignored
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check("idle_iready", 32'(a_oReady), 32'd1);

    send("clean",  21'h08C3E6, 16'h443D, 5'd0,  1'b0, 1'b0);
    release_word("clean", 5'd0);
    send("dbit5",  21'h08C3F6, 16'h443D, 5'd5,  1'b1, 1'b0);
    release_word("dbit5", 5'd5);
    send("pbit1",  21'h08C3E7, 16'h443D, 5'd1,  1'b1, 1'b0);
    release_word("pbit1", 5'd1);
    send("unc31",  21'h0803E6, 16'h403D, 5'd31, 1'b0, 1'b1);
    release_word("unc31", 5'd31);
    send("pos21",  21'h18C3E6, 16'h443D, 5'd21, 1'b1, 1'b0);
    release_word("pos21", 5'd21);
    send("unc22",  21'h18C3E2, 16'hC43C, 5'd22, 1'b0, 1'b1);
    release_word("unc22", 5'd22);

    // Fourth correction saturates the 2-bit counter; then backpressure with iValid toggling
    send("bp", 21'h08C3F6, 16'h443D, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      iValid = i[0];
      iData  = 21'h1FFFFF;
      tick();
      check("bp_valid", 32'(a_oValid), 32'd1);
      check("bp_ready", 32'(a_oReady), 32'd0);
      check("bp_data",  32'(a_oData),  32'h443D);
      check("bp_syn",   {27'd0, a_oSyndrome}, 32'd5);
    end
    iValid = 1'b0;
    release_word("bp", 5'd5);
    tick();
    check("bp_nocapture", 32'(a_oReady), 32'd1);
    check_counts("bp_after");

    // Reset during HOLD aborts the word and clears counters
    send("rhold", 21'h08C3F6, 16'h443D, 5'd5, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_corr = 0;
    exp_unc  = 0;
    check("rhold_valid",  32'(a_oValid), 32'd0);
    check("rhold_validB", 32'(b_oValid), 32'd0);
    check("rhold_ready",  32'(a_oReady), 32'd1);
    check("rhold_data",   32'(a_oData),  32'd0);
    check_counts("rhold");

    // Reset during DECODE: no handshake and no count for the aborted word
    iData  = 21'h0803E6;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rdec_valid", 32'(a_oValid), 32'd0);
    check("rdec_ready", 32'(a_oReady), 32'd1);
    check_counts("rdec");

    send("final", 21'h08C3E6, 16'h443D, 5'd0, 1'b0, 1'b0);
    release_word("final", 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
